// File: rtl/dcache_flush_unit.sv
// dcache_flush_unit
//   Responder side of the D-cache flush handshake. A rising edge on flush_i
//   starts a walk over every set (outer) and way (inner). Each line is read,
//   written back if it is both valid and dirty, and then invalidated. A
//   one-cycle flush_ack_o pulse marks the end of the walk.
//
//   Optional feature macro: DCACHE_FLUSH_WB_CNT_EN
//     defined     : wb_cnt_o counts write-backs of the most recent flush
//                   (saturating, cleared at flush start, held afterwards)
//     not defined : no counter is built and wb_cnt_o is tied to zero
//
// Ports
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   flush_i / flush_ack_o            flush request level / completion pulse
//   busy_o                           walk in progress (any state but IDLE)
//   rd_req_o / rd_gnt_i              array read handshake
//   rd_idx_o, rd_way_o               read location
//   rd_line_valid_i, rd_dirty_i      line status, one cycle after rd_gnt_i
//   rd_tag_i, rd_data_i              line contents, same cycle as status
//   wb_req_o / wb_gnt_i              write-back handshake
//   wb_addr_o, wb_data_o             {tag, idx, zero offset}, line data
//   inv_req_o / inv_gnt_i            invalidate handshake
//   inv_idx_o, inv_way_o             invalidate location
//   wb_cnt_o                         write-backs in the last flush
module dcache_flush_unit #(
    parameter int NUM_SETS   = 256,
    parameter int NUM_WAYS   = 8,
    parameter int TAG_WIDTH  = 44,
    parameter int LINE_WIDTH = 128,
    localparam int IDX_W     = $clog2(NUM_SETS),
    localparam int WAY_W     = $clog2(NUM_WAYS),
    localparam int OFF_W     = $clog2(LINE_WIDTH / 8),
    localparam int ADDR_W    = TAG_WIDTH + IDX_W + OFF_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  flush_ack_o,
    output logic                  busy_o,
    output logic                  rd_req_o,
    input  logic                  rd_gnt_i,
    output logic [IDX_W-1:0]      rd_idx_o,
    output logic [WAY_W-1:0]      rd_way_o,
    input  logic                  rd_line_valid_i,
    input  logic                  rd_dirty_i,
    input  logic [TAG_WIDTH-1:0]  rd_tag_i,
    input  logic [LINE_WIDTH-1:0] rd_data_i,
    output logic                  wb_req_o,
    input  logic                  wb_gnt_i,
    output logic [ADDR_W-1:0]     wb_addr_o,
    output logic [LINE_WIDTH-1:0] wb_data_o,
    output logic                  inv_req_o,
    input  logic                  inv_gnt_i,
    output logic [IDX_W-1:0]      inv_idx_o,
    output logic [WAY_W-1:0]      inv_way_o,
    output logic [15:0]           wb_cnt_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        WB   = 3'd3,
        INV  = 3'd4,
        DONE = 3'd5
    } state_e;

    state_e                  state_r;
    state_e                  state_s;
    logic                    flush_q_r;
    logic [IDX_W-1:0]        idx_r;
    logic [WAY_W-1:0]        way_r;
    logic [TAG_WIDTH-1:0]    tag_r;
    logic [LINE_WIDTH-1:0]   data_r;
    logic                    start_s;
    logic                    last_s;

    // Only a fresh rising edge seen while idle starts a walk; a held level never does.
    assign start_s = (state_r == IDLE) && flush_i && !flush_q_r;
    assign last_s  = (idx_r == IDX_W'(NUM_SETS - 1)) && (way_r == WAY_W'(NUM_WAYS - 1));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; grants are only looked at in the state that requests them.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_s = READ;
                else         state_s = IDLE;
            end
            READ: begin
                if (rd_gnt_i) state_s = WAIT;
                else          state_s = READ;
            end
            WAIT: begin
                // An invalid line is never written back, whatever its dirty bit says.
                if (rd_line_valid_i && rd_dirty_i) state_s = WB;
                else                               state_s = INV;
            end
            WB: begin
                if (wb_gnt_i) state_s = INV;
                else          state_s = WB;
            end
            INV: begin
                if (inv_gnt_i && last_s)  state_s = DONE;
                else if (inv_gnt_i)       state_s = READ;
                else                      state_s = INV;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        rd_req_o    = 1'b0;
        wb_req_o    = 1'b0;
        inv_req_o   = 1'b0;
        flush_ack_o = 1'b0;
        busy_o      = 1'b1;
        case (state_r)
            IDLE:    busy_o      = 1'b0;
            READ:    rd_req_o    = 1'b1;
            WAIT:    busy_o      = 1'b1;
            WB:      wb_req_o    = 1'b1;
            INV:     inv_req_o   = 1'b1;
            DONE:    flush_ack_o = 1'b1;
            default: busy_o      = 1'b0;
        endcase
    end

    // Request-edge history for flush_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_q_r <= 1'b0;
        end else begin
            flush_q_r <= flush_i;
        end
    end

    // Set/way walk counters: way is the inner loop, set the outer one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_r <= {IDX_W{1'b0}};
            way_r <= {WAY_W{1'b0}};
        end else if (start_s) begin
            idx_r <= {IDX_W{1'b0}};
            way_r <= {WAY_W{1'b0}};
        end else if ((state_r == INV) && inv_gnt_i && !last_s) begin
            if (way_r == WAY_W'(NUM_WAYS - 1)) begin
                way_r <= {WAY_W{1'b0}};
                idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                way_r <= way_r + {{(WAY_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Line capture; the array presents contents during WAIT and they stay
    // frozen for the whole (possibly stalled) write-back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_r  <= {TAG_WIDTH{1'b0}};
            data_r <= {LINE_WIDTH{1'b0}};
        end else if (state_r == WAIT) begin
            tag_r  <= rd_tag_i;
            data_r <= rd_data_i;
        end
    end

    assign rd_idx_o  = idx_r;
    assign rd_way_o  = way_r;
    assign inv_idx_o = idx_r;
    assign inv_way_o = way_r;
    assign wb_addr_o = {tag_r, idx_r, {OFF_W{1'b0}}};
    assign wb_data_o = data_r;

`ifdef DCACHE_FLUSH_WB_CNT_EN
    logic [15:0] wb_cnt_r;

    // Write-back counter: cleared at flush start, saturating, held after DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_cnt_r <= 16'd0;
        end else if (start_s) begin
            wb_cnt_r <= 16'd0;
        end else if ((state_r == WB) && wb_gnt_i && (wb_cnt_r != 16'hFFFF)) begin
            wb_cnt_r <= wb_cnt_r + 16'd1;
        end
    end

    assign wb_cnt_o = wb_cnt_r;
`else
    assign wb_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Self-checking bench for dcache_flush_unit (2 sets x 2 ways). The bench
// plays the cache arrays from a line model and predicts, per the flush rules,
// the ordered read/write-back/invalidate sequence and the acknowledge cycle.
module tb_dcache_flush_unit;

    localparam int NS = 2;
    localparam int NW = 2;
    localparam int TW = 44;
    localparam int LW = 128;
    localparam int IW = 1;
    localparam int WW = 1;
    localparam int OW = 4;
    localparam int AW = TW + IW + OW;
    localparam int N  = NS * NW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          flush_ack_o, busy_o;
    logic          rd_req_o, rd_gnt_i = 1'b0;
    logic [IW-1:0] rd_idx_o;
    logic [WW-1:0] rd_way_o;
    logic          rd_line_valid_i = 1'b0, rd_dirty_i = 1'b0;
    logic [TW-1:0] rd_tag_i = '0;
    logic [LW-1:0] rd_data_i = '0;
    logic          wb_req_o, wb_gnt_i = 1'b0;
    logic [AW-1:0] wb_addr_o;
    logic [LW-1:0] wb_data_o;
    logic          inv_req_o, inv_gnt_i = 1'b0;
    logic [IW-1:0] inv_idx_o;
    logic [WW-1:0] inv_way_o;
    logic [15:0]   wb_cnt_o;

    int checks = 0;
    int errors = 0;

    // Line model, indexed idx*NW + way.
    logic          m_valid [N];
    logic          m_dirty [N];
    logic [TW-1:0] m_tag   [N];
    logic [LW-1:0] m_data  [N];

    always #5 clk_i = ~clk_i;

    dcache_flush_unit #(
        .NUM_SETS(NS), .NUM_WAYS(NW), .TAG_WIDTH(TW), .LINE_WIDTH(LW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .flush_ack_o(flush_ack_o), .busy_o(busy_o),
        .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i),
        .rd_idx_o(rd_idx_o), .rd_way_o(rd_way_o),
        .rd_line_valid_i(rd_line_valid_i), .rd_dirty_i(rd_dirty_i),
        .rd_tag_i(rd_tag_i), .rd_data_i(rd_data_i),
        .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .inv_req_o(inv_req_o), .inv_gnt_i(inv_gnt_i),
        .inv_idx_o(inv_idx_o), .inv_way_o(inv_way_o),
        .wb_cnt_o(wb_cnt_o)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [TW-1:0] rnd_tag();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[TW-1:0];
    endfunction

    task automatic fill(input bit allow_dirty);
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'($urandom_range(0, 1));
            m_dirty[i] = allow_dirty ? 1'($urandom_range(0, 1)) : 1'b0;
            m_tag[i]   = rnd_tag();
            m_data[i]  = rnd_line();
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ack"},     flush_ack_o, 0);
        chk({pfx, "_busy"},    busy_o, 0);
        chk({pfx, "_reqs"},    {rd_req_o, wb_req_o, inv_req_o}, 0);
        chk({pfx, "_rd_loc"},  {rd_idx_o, rd_way_o}, 0);
        chk({pfx, "_inv_loc"}, {inv_idx_o, inv_way_o}, 0);
        chk({pfx, "_wb_addr"}, wb_addr_o, 0);
        chk({pfx, "_wb_data"}, wb_data_o, 0);
        chk({pfx, "_wb_cnt"},  wb_cnt_o, 0);
    endtask

    // One flush: low for a cycle, rise (cycle 0), then act as the arrays
    // cycle by cycle until the acknowledge, a timeout, or an injected reset.
    task automatic do_walk(input int stall_pct, input int wb_hold, input bit abort_wb,
                           input int hold_after, output int ack_cyc);
        int  li, lc, cyc, stalls, n_dirty, wbs;
        bit  need_wb, wb_done, rd_prev, acked, aborted;
        logic [15:0]   exp_cnt;
        logic [AW-1:0] exp_addr;
        n_dirty = 0;
        for (int i = 0; i < N; i++) if (m_valid[i] && m_dirty[i]) n_dirty++;
`ifdef DCACHE_FLUSH_WB_CNT_EN
        exp_cnt = 16'(n_dirty);
`else
        exp_cnt = 16'd0;
`endif
        li = 0; cyc = 0; stalls = 0; wbs = 0;
        wb_done = 0; rd_prev = 0; acked = 0; aborted = 0; ack_cyc = -1;
        @(negedge clk_i); flush_i = 1'b0;
        @(negedge clk_i); flush_i = 1'b1;
        @(posedge clk_i);
        while (!acked && !aborted) begin
            @(negedge clk_i);
            cyc++;
            rd_gnt_i = 1'b0; wb_gnt_i = 1'b0; inv_gnt_i = 1'b0;
            lc = (li < N) ? li : N - 1;
            if (rd_prev) begin
                rd_line_valid_i = m_valid[lc]; rd_dirty_i = m_dirty[lc];
                rd_tag_i = m_tag[lc];          rd_data_i = m_data[lc];
            end else begin
                rd_line_valid_i = 1'($urandom_range(0, 1)); rd_dirty_i = 1'($urandom_range(0, 1));
                rd_tag_i = rnd_tag(); rd_data_i = rnd_line();
            end
            rd_prev = 0;
            if (hold_after == 0) flush_i = 1'($urandom_range(0, 1));
            if (cyc > 500) begin
                chk("walk_timeout", 1, 0);
                break;
            end
            chk("busy", busy_o, 1);
            chk("one_req", 1'($countones({rd_req_o, wb_req_o, inv_req_o}) <= 1), 1);
            need_wb = (li < N) && m_valid[lc] && m_dirty[lc];
            if (flush_ack_o) begin
                chk("ack_cycle", cyc, 1 + 3 * (N - n_dirty) + 4 * n_dirty + stalls);
                chk("ack_all_lines", li, N);
                chk("wb_count", wbs, n_dirty);
                chk("wb_cnt_o", wb_cnt_o, exp_cnt);
                ack_cyc = cyc;
                acked = 1;
            end else if (rd_req_o) begin
                chk("rd_loc", {rd_idx_o, rd_way_o}, {IW'(lc / NW), WW'(lc % NW)});
                if ($urandom_range(0, 99) < stall_pct) stalls++;
                else begin rd_gnt_i = 1'b1; rd_prev = 1; end
            end else if (wb_req_o) begin
                chk("wb_needed", need_wb, 1);
                exp_addr = {m_tag[lc], IW'(lc / NW), OW'(0)};
                chk("wb_addr", wb_addr_o, exp_addr);
                chk("wb_data", wb_data_o, m_data[lc]);
                if (abort_wb && wbs >= 1) begin
                    rst_ni = 1'b0; flush_i = 1'b0;
                    @(posedge clk_i); #1;
                    chk_reset_outputs("rst_mid");
                    @(negedge clk_i); rst_ni = 1'b1;
                    repeat (3) begin
                        @(negedge clk_i);
                        chk("rst_no_ack", flush_ack_o, 0);
                        chk("rst_idle", busy_o, 0);
                    end
                    aborted = 1;
                end else if (wb_hold > 0) begin
                    wb_hold--; stalls++;
                end else if ($urandom_range(0, 99) < stall_pct) begin
                    stalls++;
                end else begin
                    wb_gnt_i = 1'b1; wb_done = 1; wbs++;
                end
            end else if (inv_req_o) begin
                chk("inv_loc", {inv_idx_o, inv_way_o}, {IW'(lc / NW), WW'(lc % NW)});
                chk("wb_before_inv", wb_done, need_wb);
                if ($urandom_range(0, 99) < stall_pct) stalls++;
                else begin
                    inv_gnt_i = 1'b1;
                    m_valid[lc] = 1'b0; m_dirty[lc] = 1'b0;
                    li++; wb_done = 0;
                end
            end
        end
        rd_gnt_i = 1'b0; wb_gnt_i = 1'b0; inv_gnt_i = 1'b0;
        if (acked) begin
            @(negedge clk_i);
            chk("ack_one_cycle", flush_ack_o, 0);
            chk("idle_after", busy_o, 0);
            repeat (hold_after) begin
                @(negedge clk_i);
                chk("held_no_ack", flush_ack_o, 0);
                chk("held_idle", busy_o, 0);
            end
            chk("cnt_held", wb_cnt_o, exp_cnt);
        end
    endtask

    initial begin
        int ack;
        // Reset values.
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk_i); rst_ni = 1'b1;

        // All clean, immediate grants: ack at cycle 13.
        fill(1'b0);
        do_walk(0, 0, 1'b0, 0, ack);
        chk("ack13", ack, 13);

        // Line (1,0) dirty with tag 0x5A: one write-back, ack at cycle 14.
        fill(1'b0);
        m_valid[2] = 1'b1; m_dirty[2] = 1'b1; m_tag[2] = 44'h5A;
        do_walk(0, 0, 1'b0, 0, ack);
        chk("ack14", ack, 14);

        // Dirty but invalid lines are never written back.
        fill(1'b0);
        for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b1; end
        do_walk(0, 0, 1'b0, 0, ack);
        chk("ack_invalid_dirty", ack, 13);

        // Write-back grant withheld 5 cycles: same line, ack 5 cycles later.
        fill(1'b0);
        m_valid[2] = 1'b1; m_dirty[2] = 1'b1; m_tag[2] = 44'h5A;
        do_walk(0, 5, 1'b0, 0, ack);
        chk("ack_wb_stall", ack, 19);

        // Level held 30 cycles past ack, then a 1-cycle drop restarts the walk.
        fill(1'b1);
        do_walk(0, 0, 1'b0, 30, ack);
        fill(1'b1);
        do_walk(0, 0, 1'b0, 0, ack);

        // Randomized contents, grant stalls and mid-walk flush_i toggling.
        for (int r = 0; r < 8; r++) begin
            fill(1'b1);
            do_walk(40, 0, 1'b0, 0, ack);
        end

        // Reset during a stalled write-back, then a fresh flush.
        fill(1'b1);
        m_valid[0] = 1'b1; m_dirty[0] = 1'b1;
        m_valid[1] = 1'b1; m_dirty[1] = 1'b1;
        do_walk(0, 0, 1'b1, 0, ack);
        fill(1'b1);
        do_walk(0, 0, 1'b0, 0, ack);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
